// File: rtl/white_blob_tracker_pkg.sv
// tracker_pkg: shared definitions for the white blob tracker.
//   state_t       FSM encoding (WAIT_SOF, ACCUM)
//   DEF_*_ACTIVE  default raster size
//   coord_w()     width of a coordinate that spans 0..n-1
//   count_w()     width of a hit counter that spans 0..h*v
// The result record depends on the instance's widths, so it is declared
// inside white_blob_tracker from the widths computed here.
package tracker_pkg;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACCUM    = 1'b1
   } state_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;

   function automatic int coord_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int count_w(input int h, input int v);
      return $clog2(h * v + 1);
   endfunction

endpackage

// File: rtl/white_blob_tracker_coord.sv
// pixel_coord_counter: raster position of the next expected pixel.
//   clk, reset   pixel clock, async active-high reset
//   pix_valid    a pixel is on the bus this cycle
//   pix_sof      with pix_valid: the pixel on the bus is (0,0)
//   active       a frame is in progress (valid pixels advance the raster)
//   x, y         position the next non-sof pixel occupies
//   last_pixel   x,y is the final pixel of the frame
module pixel_coord_counter
   import tracker_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int XW       = coord_w(H_ACTIVE),
   parameter int YW       = coord_w(V_ACTIVE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_valid,
   input  logic          pix_sof,
   input  logic          active,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last_pixel
);

   logic x_end, y_end;

   assign x_end      = (x == XW'(H_ACTIVE - 1));
   assign y_end      = (y == YW'(V_ACTIVE - 1));
   assign last_pixel = x_end && y_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (pix_valid && pix_sof) begin
         // the sof pixel itself sits at (0,0); the next one is (1,0)
         if (H_ACTIVE > 1) begin
            x <= XW'(1);
            y <= '0;
         end else begin
            x <= '0;
            y <= YW'(1);
         end
      end else if (pix_valid && active) begin
         if (x_end) begin
            x <= '0;
            y <= y_end ? '0 : y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

endmodule

// File: rtl/white_blob_tracker.sv
// white_blob_tracker: bounding box, centre and hit count of the white region
// in each frame of a binarised RGB565 pixel stream.
//   clk, reset            pixel clock, async active-high reset
//   pix_valid/sof/data    input pixel stream; sof marks pixel (0,0)
//   res_valid             1-cycle pulse, res_* hold a newly completed frame
//   res_abort             1-cycle pulse, frame dropped by an early sof
//   res_found             res_count >= MIN_COUNT
//   res_min/max_x/y       hit bounding box, res_cx/cy its floor centre
//   res_count             number of hit pixels in the frame
module white_blob_tracker
   import tracker_pkg::*;
#(
   parameter int          H_ACTIVE  = DEF_H_ACTIVE,
   parameter int          V_ACTIVE  = DEF_V_ACTIVE,
   parameter logic [15:0] HIT_MASK  = 16'hFFFF,
   parameter int          MIN_COUNT = 4,
   parameter int          XW        = coord_w(H_ACTIVE),
   parameter int          YW        = coord_w(V_ACTIVE),
   parameter int          CW        = count_w(H_ACTIVE, V_ACTIVE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_valid,
   input  logic          pix_sof,
   input  logic [15:0]   pix_data,
   output logic          res_valid,
   output logic          res_abort,
   output logic          res_found,
   output logic [XW-1:0] res_min_x,
   output logic [XW-1:0] res_max_x,
   output logic [YW-1:0] res_min_y,
   output logic [YW-1:0] res_max_y,
   output logic [XW-1:0] res_cx,
   output logic [YW-1:0] res_cy,
   output logic [CW-1:0] res_count
);

   typedef struct packed {
      logic [XW-1:0] min_x;
      logic [XW-1:0] max_x;
      logic [YW-1:0] min_y;
      logic [YW-1:0] max_y;
      logic [XW-1:0] cx;
      logic [YW-1:0] cy;
      logic [CW-1:0] count;
      logic          found;
   } result_t;

   state_t        state, state_nx;
   logic [XW-1:0] x, cur_x;
   logic [YW-1:0] y, cur_y;
   logic          last_pixel, hit;
   logic          accept, frame_done, frame_abort;

   logic [XW-1:0] min_x, max_x, base_min_x, base_max_x, nx_min_x, nx_max_x;
   logic [YW-1:0] min_y, max_y, base_min_y, base_max_y, nx_min_y, nx_max_y;
   logic [CW-1:0] count, base_count, nx_count;
   logic [XW:0]   sum_x;
   logic [YW:0]   sum_y;
   result_t       fin, res;

   pixel_coord_counter #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .XW       (XW),
      .YW       (YW)
   ) u_coord (
      .clk        (clk),
      .reset      (reset),
      .pix_valid  (pix_valid),
      .pix_sof    (pix_sof),
      .active     (state == ACCUM),
      .x          (x),
      .y          (y),
      .last_pixel (last_pixel)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= WAIT_SOF;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      accept      = 1'b0;
      frame_done  = 1'b0;
      frame_abort = 1'b0;
      case (state)
         WAIT_SOF: begin
            // stray pixels before a sof are dropped
            if (pix_valid && pix_sof) begin
               accept   = 1'b1;
               state_nx = ACCUM;
            end
         end
         ACCUM: begin
            if (pix_valid) begin
               accept = 1'b1;
               // a sof wins over last_pixel: the frame restarts here
               if (pix_sof) begin
                  frame_abort = 1'b1;
               end else if (last_pixel) begin
                  frame_done = 1'b1;
                  state_nx   = WAIT_SOF;
               end
            end
         end
         default: state_nx = WAIT_SOF;
      endcase
   end

   // ---------------- accumulators ----------------
   assign cur_x = pix_sof ? '0 : x;
   assign cur_y = pix_sof ? '0 : y;
   assign hit   = ((pix_data & HIT_MASK) == HIT_MASK);

   // the sof pixel starts from fresh accumulator values, so the frame
   // restart and the evaluation of pixel (0,0) happen in one cycle
   always_comb begin
      base_min_x = pix_sof ? '1 : min_x;
      base_max_x = pix_sof ? '0 : max_x;
      base_min_y = pix_sof ? '1 : min_y;
      base_max_y = pix_sof ? '0 : max_y;
      base_count = pix_sof ? '0 : count;
      nx_min_x   = base_min_x;
      nx_max_x   = base_max_x;
      nx_min_y   = base_min_y;
      nx_max_y   = base_max_y;
      nx_count   = base_count;
      if (hit) begin
         if (cur_x < base_min_x) nx_min_x = cur_x;
         if (cur_x > base_max_x) nx_max_x = cur_x;
         if (cur_y < base_min_y) nx_min_y = cur_y;
         if (cur_y > base_max_y) nx_max_y = cur_y;
         nx_count = base_count + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min_x <= '1;
         max_x <= '0;
         min_y <= '1;
         max_y <= '0;
         count <= '0;
      end else if (accept) begin
         min_x <= nx_min_x;
         max_x <= nx_max_x;
         min_y <= nx_min_y;
         max_y <= nx_max_y;
         count <= nx_count;
      end
   end

   // ---------------- result ----------------
   // one extra bit keeps min+max from wrapping before the halving
   assign sum_x = {1'b0, nx_min_x} + {1'b0, nx_max_x};
   assign sum_y = {1'b0, nx_min_y} + {1'b0, nx_max_y};

   always_comb begin
      fin = '0;
      // an empty frame reports zeros, not the all-ones min seeds
      if (nx_count != '0) begin
         fin.min_x = nx_min_x;
         fin.max_x = nx_max_x;
         fin.min_y = nx_min_y;
         fin.max_y = nx_max_y;
         fin.cx    = sum_x[XW:1];
         fin.cy    = sum_y[YW:1];
         fin.count = nx_count;
         fin.found = (nx_count >= CW'(MIN_COUNT));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res       <= '0;
         res_valid <= 1'b0;
         res_abort <= 1'b0;
      end else begin
         res_valid <= frame_done;
         res_abort <= frame_abort;
         if (frame_done) res <= fin;
      end
   end

   assign res_min_x = res.min_x;
   assign res_max_x = res.max_x;
   assign res_min_y = res.min_y;
   assign res_max_y = res.max_y;
   assign res_cx    = res.cx;
   assign res_cy    = res.cy;
   assign res_count = res.count;
   assign res_found = res.found;

endmodule

// File: tb/tb_white_blob_tracker.sv
// tb_white_blob_tracker: directed frames on a reduced 128x56 raster with
// MIN_COUNT=2; expected results are computed by hand for each pattern.
module tb_white_blob_tracker;

   localparam int H    = 128;
   localparam int V    = 56;
   localparam int MINC = 2;
   localparam int XW   = 7;
   localparam int YW   = 6;
   localparam int CW   = 13;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pix_valid = 1'b0;
   logic          pix_sof = 1'b0;
   logic [15:0]   pix_data = '0;
   logic          res_valid, res_abort, res_found;
   logic [XW-1:0] res_min_x, res_max_x, res_cx;
   logic [YW-1:0] res_min_y, res_max_y, res_cy;
   logic [CW-1:0] res_count;

   white_blob_tracker #(
      .H_ACTIVE  (H),
      .V_ACTIVE  (V),
      .HIT_MASK  (16'hFFFF),
      .MIN_COUNT (MINC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pix_valid (pix_valid),
      .pix_sof   (pix_sof),
      .pix_data  (pix_data),
      .res_valid (res_valid),
      .res_abort (res_abort),
      .res_found (res_found),
      .res_min_x (res_min_x),
      .res_max_x (res_max_x),
      .res_min_y (res_min_y),
      .res_max_y (res_max_y),
      .res_cx    (res_cx),
      .res_cy    (res_cy),
      .res_count (res_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   int n_valid = 0, n_abort = 0, valid_cyc = 0, last_cyc = 0, abort_cnt = -1;
   int v0, a0;

   always @(negedge clk) begin
      if (res_valid) begin
         n_valid++;
         valid_cyc = cyc;
      end
      if (res_abort) begin
         n_abort++;
         abort_cnt = int'(res_count);
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_res(input string tag, input int mnx, input int mxx, input int mny,
                            input int mxy, input int cx, input int cy, input int cnt,
                            input int fnd);
      check({tag, ".min_x"}, 32'(res_min_x), mnx);
      check({tag, ".max_x"}, 32'(res_max_x), mxx);
      check({tag, ".min_y"}, 32'(res_min_y), mny);
      check({tag, ".max_y"}, 32'(res_max_y), mxy);
      check({tag, ".cx"},    32'(res_cx),    cx);
      check({tag, ".cy"},    32'(res_cy),    cy);
      check({tag, ".count"}, 32'(res_count), cnt);
      check({tag, ".found"}, 32'(res_found), fnd);
   endtask

   // 0 zeros, 1 3x3 square (near-white background), 2 two corners,
   // 3 red everywhere, 4 single hit at (5,7)
   function automatic logic [15:0] pix_at(input int md, input int x, input int y);
      case (md)
         1:       return (x >= 100 && x <= 102 && y >= 50 && y <= 52) ? 16'hFFFF : 16'hFFDF;
         2:       return ((x == 0 && y == 0) || (x == H-1 && y == V-1)) ? 16'hFFFF : 16'h0000;
         3:       return 16'hF800;
         4:       return (x == 5 && y == 7) ? 16'hFFFF : 16'h0000;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_valid = 1'b0;
         pix_sof   = 1'b0;
      end
   endtask

   task automatic drive_px(input logic [15:0] d, input logic sof, input int gap);
      if (gap > 0 && $urandom_range(99) < gap) idle(1);
      @(negedge clk);
      pix_valid = 1'b1;
      pix_sof   = sof;
      pix_data  = d;
      last_cyc  = cyc;
   endtask

   // stop_n > 0 sends only the first stop_n pixels of the frame
   task automatic send_frame(input int md, input int gap, input int stop_n);
      int n = 0;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) begin
            if (stop_n > 0 && n == stop_n) return;
            drive_px(pix_at(md, x, y), (x == 0 && y == 0), gap);
            n++;
         end
      idle(3);
   endtask

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(3);
      check_res("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      check("reset.valid", 32'(res_valid), 0);
      check("reset.abort", 32'(res_abort), 0);
      reset = 1'b0;
      idle(2);

      // hits before any sof are ignored
      for (int i = 0; i < 30; i++) drive_px(16'hFFFF, 1'b0, 0);
      idle(3);
      check("nosof.valid", n_valid, 0);
      check("nosof.count", 32'(res_count), 0);

      // reset mid-frame: no pulses, then a blank frame
      send_frame(1, 0, 500);
      @(negedge clk);
      pix_valid = 1'b0;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(2);
      check("rstmid.valid", n_valid, 0);
      check("rstmid.abort", n_abort, 0);
      send_frame(0, 0, 0);
      check("zero.valid", n_valid, 1);
      check_res("zero", 0, 0, 0, 0, 0, 0, 0, 0);

      // 3x3 square
      v0 = n_valid;
      send_frame(1, 0, 0);
      check("sq.valid", n_valid - v0, 1);
      check("sq.latency", valid_cyc - last_cyc, 1);
      check_res("sq", 100, 102, 50, 52, 101, 51, 9, 1);

      // corner hits incl. the last pixel
      v0 = n_valid;
      send_frame(2, 0, 0);
      check("corner.valid", n_valid - v0, 1);
      check_res("corner", 0, H-1, 0, V-1, 63, 27, 2, 1);

      // one hit: box reported, below MIN_COUNT
      send_frame(4, 0, 0);
      check_res("single", 5, 5, 7, 7, 5, 7, 1, 0);

      // early sof at (10,40) after a partial frame with a hit at (0,0),
      // followed by the square frame with ~30% idle cycles
      v0 = n_valid;
      a0 = n_abort;
      send_frame(2, 0, 40 * H + 10);
      send_frame(1, 30, 0);
      check("abort.pulses", n_abort - a0, 1);
      check("abort.held_count", abort_cnt, 1);
      check("gap.valid", n_valid - v0, 1);
      check("gap.latency", valid_cyc - last_cyc, 1);
      check_res("gap", 100, 102, 50, 52, 101, 51, 9, 1);

      // red only: no hits under the full mask
      v0 = n_valid;
      send_frame(3, 0, 0);
      check("red.valid", n_valid - v0, 1);
      check_res("red", 0, 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
